// File: rtl/rx_uart.sv
// 8N1 UART receiver: synchronises the serial line, validates the start bit at
// mid-bit, samples each data bit at its centre and checks the stop bit.
module rx_uart #(
  parameter int unsigned CYCLE_PER_BIT = 115
) (
  input  logic       clk_rx,
  input  logic       rst_rx,
  input  logic       enable_rx,
  input  logic       in_serial_rx,
  output logic [7:0] out_byte_rx,
  output logic       out_valid_rx,
  output logic       out_err_rx
);

  localparam int unsigned HALF_BIT = CYCLE_PER_BIT / 2;
  localparam logic [7:0]  HALF_LAST = 8'(HALF_BIT - 1);
  localparam logic [7:0]  BIT_LAST  = 8'(CYCLE_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BIT  = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] clk_count;
  logic [2:0] data_index;
  logic [7:0] shift_reg;
  logic [1:0] sync_q;
  logic       rx_s;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], in_serial_rx};
    end
  end

  assign rx_s = sync_q[1];

  // Receive FSM with registered byte and pulse outputs.
  always_ff @(posedge clk_rx or posedge rst_rx) begin
    if (rst_rx) begin
      state        <= IDLE;
      clk_count    <= 8'd0;
      data_index   <= 3'd0;
      shift_reg    <= 8'd0;
      out_byte_rx  <= 8'd0;
      out_valid_rx <= 1'b0;
      out_err_rx   <= 1'b0;
    end else begin
      out_valid_rx <= 1'b0;
      out_err_rx   <= 1'b0;
      if (!enable_rx) begin
        state      <= IDLE;
        clk_count  <= 8'd0;
        data_index <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            clk_count  <= 8'd0;
            data_index <= 3'd0;
            if (!rx_s) state <= START_BIT;
          end
          START_BIT: begin
            if (clk_count == HALF_LAST) begin
              clk_count <= 8'd0;
              state     <= rx_s ? IDLE : DATA_BIT;
            end else begin
              clk_count <= clk_count + 8'd1;
            end
          end
          DATA_BIT: begin
            if (clk_count == BIT_LAST) begin
              clk_count             <= 8'd0;
              shift_reg[data_index] <= rx_s;
              // Natural 3-bit wrap returns the index to 0 on the exit to STOP_BIT.
              data_index            <= data_index + 3'd1;
              if (data_index == 3'd7) state <= STOP_BIT;
            end else begin
              clk_count <= clk_count + 8'd1;
            end
          end
          STOP_BIT: begin
            if (clk_count == BIT_LAST) begin
              clk_count <= 8'd0;
              if (rx_s) begin
                out_byte_rx  <= shift_reg;
                out_valid_rx <= 1'b1;
                state        <= IDLE;
              end else begin
                out_err_rx <= 1'b1;
                state      <= WAIT_HIGH;
              end
            end else begin
              clk_count <= clk_count + 8'd1;
            end
          end
          WAIT_HIGH: begin
            // Hold off until the line recovers so a stuck-low line cannot retrigger.
            clk_count <= 8'd0;
            if (rx_s) state <= IDLE;
          end
          default: begin
            state      <= IDLE;
            clk_count  <= 8'd0;
            data_index <= 3'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_uart.sv
// Self-checking bench for rx_uart: table of frames plus hand-written corner
// sequences, with a scoreboard queue matched against the DUT output pulses.
module tb_rx_uart;

  localparam int unsigned CPB = 115;
  // Line edge driven at a negedge -> pulse seen at the negedge with cyc = t + LAT.
  localparam int unsigned LAT = 1095;

  logic       clk_rx = 1'b0;
  logic       rst_rx;
  logic       enable_rx;
  logic       in_serial_rx;
  logic [7:0] out_byte_rx;
  logic       out_valid_rx;
  logic       out_err_rx;

  rx_uart #(.CYCLE_PER_BIT(CPB)) dut (
    .clk_rx      (clk_rx),
    .rst_rx      (rst_rx),
    .enable_rx   (enable_rx),
    .in_serial_rx(in_serial_rx),
    .out_byte_rx (out_byte_rx),
    .out_valid_rx(out_valid_rx),
    .out_err_rx  (out_err_rx)
  );

  always #5 clk_rx = ~clk_rx;

  typedef struct {
    logic        is_err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic        stop_ok;
    int unsigned stop_len;
    int unsigned gap;
  } vec_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [7:0]  last_good = 8'h00;
  logic        prev_pulse = 1'b0;

  always @(posedge clk_rx) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every output pulse must match the oldest expected event.
  always @(negedge clk_rx) begin
    exp_t e;
    if (!rst_rx && (out_valid_rx || out_err_rx)) begin
      check("pulse_exclusive", 32'(out_valid_rx & out_err_rx), 32'd0);
      check("pulse_single_cycle", 32'(prev_pulse), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b byte=0x%0h, required no pulse (cycle %0d)",
                 out_valid_rx, out_err_rx, out_byte_rx, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_err", 32'(out_err_rx), 32'(e.is_err));
        check("pulse_cycle", cyc, e.cyc);
        if (e.is_err) begin
          check("err_byte_held", 32'(out_byte_rx), 32'(last_good));
        end else begin
          check("rx_byte", 32'(out_byte_rx), 32'(e.data));
          last_good = e.data;
        end
      end
    end
    prev_pulse = !rst_rx && (out_valid_rx || out_err_rx);
  end

  // Drives one frame starting at the current negedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok,
                            input int unsigned stop_len, input logic expect_out);
    exp_t e;
    if (expect_out) begin
      e.is_err = !stop_ok;
      e.data   = b;
      e.cyc    = cyc + LAT;
      exp_q.push_back(e);
    end
    in_serial_rx = 1'b0;
    repeat (CPB) @(negedge clk_rx);
    for (int i = 0; i < 8; i++) begin
      in_serial_rx = b[i];
      repeat (CPB) @(negedge clk_rx);
    end
    in_serial_rx = stop_ok;
    repeat (stop_len) @(negedge clk_rx);
    in_serial_rx = 1'b1;
  endtask

  task automatic wait_drain(input int unsigned max_cycles);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk_rx);
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  vec_t vecs[6];

  initial begin
    int unsigned t;

    vecs[0] = '{8'hA5, 1'b1, CPB, 200};
    vecs[1] = '{8'h00, 1'b1, CPB, 0};
    vecs[2] = '{8'hFF, 1'b1, CPB, 200};
    vecs[3] = '{8'h55, 1'b0, 300, 200};
    vecs[4] = '{8'h81, 1'b1, CPB, 200};
    vecs[5] = '{8'hC3, 1'b1, CPB, 50};

    rst_rx       = 1'b1;
    enable_rx    = 1'b1;
    in_serial_rx = 1'b1;
    repeat (4) @(negedge clk_rx);
    check("reset_byte", 32'(out_byte_rx), 32'h00);
    check("reset_valid", 32'(out_valid_rx), 32'd0);
    check("reset_err", 32'(out_err_rx), 32'd0);
    check("reset_state", 32'(dut.state), 32'd0);
    rst_rx = 1'b0;
    repeat (10) @(negedge clk_rx);

    // Table: normal, back-to-back (0x00 then 0xFF, no gap), framing error, recovery.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].stop_len, 1'b1);
      repeat (vecs[v].gap) @(negedge clk_rx);
    end
    wait_drain(2000);
    check("byte_after_table", 32'(out_byte_rx), 32'hC3);

    // Short low glitch: rejected at start-bit centre, no pulse.
    t = cyc;
    in_serial_rx = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk_rx);
      if (k == 20) in_serial_rx = 1'b1;
      if (k == 59) check("glitch_still_start", 32'(dut.state), 32'd1);
      if (k == 60) check("glitch_back_idle", 32'(dut.state), 32'd0);
    end
    repeat (100) @(negedge clk_rx);
    send_frame(8'h3C, 1'b1, CPB, 1'b1);
    repeat (50) @(negedge clk_rx);
    wait_drain(2000);

    // Receiver disabled during data bit 4: frame discarded silently.
    fork
      send_frame(8'h96, 1'b1, CPB, 1'b0);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge clk_rx);
        enable_rx = 1'b0;
        repeat (2) @(negedge clk_rx);
        check("disable_state_idle", 32'(dut.state), 32'd0);
        check("disable_count_clear", 32'(dut.clk_count), 32'd0);
      end
    join
    check("disable_byte_held", 32'(out_byte_rx), 32'h3C);
    repeat (50) @(negedge clk_rx);
    enable_rx = 1'b1;
    repeat (20) @(negedge clk_rx);
    send_frame(8'h96, 1'b1, CPB, 1'b1);
    repeat (50) @(negedge clk_rx);
    wait_drain(2000);

    // Reset mid-frame: outputs clear at once; released once the line is idle.
    fork
      send_frame(8'hE7, 1'b1, CPB, 1'b0);
      begin
        repeat (400) @(negedge clk_rx);
        rst_rx = 1'b1;
        #1;
        check("midrst_byte", 32'(out_byte_rx), 32'h00);
        check("midrst_valid", 32'(out_valid_rx), 32'd0);
        check("midrst_err", 32'(out_err_rx), 32'd0);
        check("midrst_state", 32'(dut.state), 32'd0);
      end
    join
    last_good = 8'h00;
    repeat (20) @(negedge clk_rx);
    rst_rx = 1'b0;
    repeat (20) @(negedge clk_rx);
    send_frame(8'h7E, 1'b1, CPB, 1'b1);
    repeat (50) @(negedge clk_rx);
    wait_drain(2000);
    check("final_byte", 32'(out_byte_rx), 32'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
